// File: rtl/song_sequencer_pkg.sv
// Shared types and constants for the song sequencer.
// Holds the FSM state encoding and the special ROM byte values.
package song_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_GAP
  } state_t;

  localparam logic [7:0] END_MARKER = 8'hFF;
  localparam logic [7:0] REST_NOTE  = 8'h00;

endpackage

// File: rtl/song_sequencer_step_timer.sv
// Per-step cycle counter with gap and end-of-step compare points.
// Ports: clock, reset, clear, enable in; gap_hit, step_hit out.
module step_timer #(
  parameter int TICKS_PER_STEP = 33554432,
  parameter int GAP_TICKS      = 1048576
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic gap_hit,
  output logic step_hit
);

  localparam int CW = $clog2(TICKS_PER_STEP);

  localparam logic [CW-1:0] GAP_AT =
    CW'(TICKS_PER_STEP - GAP_TICKS - 1);
  localparam logic [CW-1:0] STEP_AT =
    CW'(TICKS_PER_STEP - 1);

  logic [CW-1:0] cnt;

  assign gap_hit  = enable && (cnt == GAP_AT);
  assign step_hit = enable && (cnt == STEP_AT);

  // Restart on the last tick so the counter never wraps,
  // even when TICKS_PER_STEP is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || step_hit) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Walks a synchronous song ROM and drives note codes step by step.
// Ports: clock, reset, start, stop, rom_data in; rom_addr, fullnote, playing, song_end out.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TICKS_PER_STEP = 33554432,
  parameter int GAP_TICKS      = 1048576,
  parameter int LOOP           = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        fullnote,
  output logic              playing,
  output logic              song_end
);

  state_t state;
  logic   t_clear;
  logic   t_en;
  logic   gap_hit;
  logic   step_hit;

  assign t_clear = stop || (state == S_LATCH);
  assign t_en    = !stop &&
                   ((state == S_PLAY) || (state == S_GAP));

  step_timer #(
    .TICKS_PER_STEP (TICKS_PER_STEP),
    .GAP_TICKS      (GAP_TICKS)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (t_clear),
    .enable   (t_en),
    .gap_hit  (gap_hit),
    .step_hit (step_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      fullnote <= REST_NOTE;
      playing  <= 1'b0;
      song_end <= 1'b0;
    end else begin
      song_end <= 1'b0;
      if (stop) begin
        state    <= S_IDLE;
        fullnote <= REST_NOTE;
        playing  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              rom_addr <= '0;
              state    <= S_FETCH;
              playing  <= 1'b1;
            end
          end
          S_FETCH: state <= S_LATCH;
          S_LATCH: begin
            if (rom_data == END_MARKER) begin
              song_end <= 1'b1;
              fullnote <= REST_NOTE;
              if (LOOP != 0) begin
                rom_addr <= '0;
                state    <= S_FETCH;
              end else begin
                state   <= S_IDLE;
                playing <= 1'b0;
              end
            end else begin
              fullnote <= rom_data;
              state    <= S_PLAY;
            end
          end
          // step_hit wins so GAP_TICKS=0 advances directly
          S_PLAY: begin
            if (step_hit) begin
              rom_addr <= rom_addr + 1'b1;
              fullnote <= REST_NOTE;
              state    <= S_FETCH;
            end else if (gap_hit) begin
              fullnote <= REST_NOTE;
              state    <= S_GAP;
            end
          end
          S_GAP: begin
            if (step_hit) begin
              rom_addr <= rom_addr + 1'b1;
              state    <= S_FETCH;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench: looping and one-shot sequencers on a 4-entry song.
// Checks step timing, end marker, stop, start/stop clash and async reset.
module tb_song_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_a;
  logic       start_b;
  logic       stop;
  logic [3:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic [7:0] note_a, note_b;
  logic       play_a, play_b;
  logic       end_a, end_b;

  logic [7:0] rom [16];

  int nvec = 0;
  int nerr = 0;
  int ends = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    data_a <= rom[addr_a];
    data_b <= rom[addr_b];
  end

  song_sequencer #(
    .ADDR_W(4), .TICKS_PER_STEP(8),
    .GAP_TICKS(2), .LOOP(1)
  ) dut_a (
    .clock(clock), .reset(reset),
    .start(start_a), .stop(stop),
    .rom_addr(addr_a), .rom_data(data_a),
    .fullnote(note_a), .playing(play_a),
    .song_end(end_a)
  );

  song_sequencer #(
    .ADDR_W(4), .TICKS_PER_STEP(8),
    .GAP_TICKS(2), .LOOP(0)
  ) dut_b (
    .clock(clock), .reset(reset),
    .start(start_b), .stop(stop),
    .rom_addr(addr_b), .rom_data(data_b),
    .fullnote(note_b), .playing(play_b),
    .song_end(end_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h21;
    rom[1] = 8'h00;
    rom[2] = 8'h35;
    rom[3] = 8'hFF;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    stop    = 1'b0;
    #1;
    chk("rst_note", {24'h0, note_a}, 32'h00);
    chk("rst_play", {31'h0, play_a}, 32'h0);
    chk("rst_addr", {28'h0, addr_a}, 32'h0);
    chk("rst_end", {31'h0, end_a}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("idle_hold", {31'h0, play_a}, 32'h0);

    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    chk("e1_addr", {28'h0, addr_a}, 32'h0);
    chk("e1_play", {31'h0, play_a}, 32'h1);
    tick();
    chk("e2_note", {24'h0, note_a}, 32'h00);

    // k counts edges since the start edge
    for (int k = 2; k <= 55; k++) begin
      if (k == 4) start_a = 1'b1;
      if (k == 5) start_a = 1'b0;
      if (k == 36) start_b = 1'b1;
      if (k == 37) start_b = 1'b0;
      tick();
      if (end_a) ends++;
      if (k >= 2 && k <= 7)
        chk("s0_note", {24'h0, note_a}, 32'h21);
      if (k == 8 || k == 9)
        chk("s0_gap", {24'h0, note_a}, 32'h00);
      if (k == 10)
        chk("s1_addr", {28'h0, addr_a}, 32'h1);
      if (k == 12) begin
        chk("s1_rest", {24'h0, note_a}, 32'h00);
        chk("s1_play", {31'h0, play_a}, 32'h1);
      end
      if (k == 20)
        chk("s2_addr", {28'h0, addr_a}, 32'h2);
      if (k == 22 || k == 27)
        chk("s2_note", {24'h0, note_a}, 32'h35);
      if (k == 28)
        chk("s2_gap", {24'h0, note_a}, 32'h00);
      if (k == 30)
        chk("s3_addr", {28'h0, addr_a}, 32'h3);
      if (k == 32) begin
        chk("mk_end", {31'h0, end_a}, 32'h1);
        chk("mk_addr", {28'h0, addr_a}, 32'h0);
        chk("mk_note", {24'h0, note_a}, 32'h00);
        chk("b_end", {31'h0, end_b}, 32'h1);
        chk("b_idle", {31'h0, play_b}, 32'h0);
      end
      if (k == 33)
        chk("mk_pulse", {31'h0, end_a}, 32'h0);
      if (k == 34)
        chk("loop_note", {24'h0, note_a}, 32'h21);
      if (k == 35)
        chk("b_stay", {31'h0, play_b}, 32'h0);
      if (k == 37) begin
        chk("b_rs_addr", {28'h0, addr_b}, 32'h0);
        chk("b_rs_play", {31'h0, play_b}, 32'h1);
      end
      if (k == 39)
        chk("b_rs_note", {24'h0, note_b}, 32'h21);
      if (k == 55) begin
        chk("pre_stop_note", {24'h0, note_a}, 32'h35);
        chk("pre_stop_addr", {28'h0, addr_a}, 32'h2);
      end
    end
    chk("end_count", ends, 32'd1);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_note", {24'h0, note_a}, 32'h00);
    chk("stop_play", {31'h0, play_a}, 32'h0);
    chk("stop_addr", {28'h0, addr_a}, 32'h2);
    tick();
    tick();
    chk("stop_idle", {31'h0, play_a}, 32'h0);

    start_a = 1'b1;
    stop    = 1'b1;
    tick();
    start_a = 1'b0;
    stop    = 1'b0;
    chk("clash_play", {31'h0, play_a}, 32'h0);
    tick();
    chk("clash_idle", {31'h0, play_a}, 32'h0);
    chk("clash_addr", {28'h0, addr_a}, 32'h2);

    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_note", {24'h0, note_a}, 32'h21);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_note", {24'h0, note_a}, 32'h00);
    chk("ar_play", {31'h0, play_a}, 32'h0);
    chk("ar_addr", {28'h0, addr_a}, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ar_idle", {31'h0, play_a}, 32'h0);
    chk("ar_quiet", {24'h0, note_a}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
